// File: rtl/sc_mux_scan.sv
// ---------------------------------------------------------------------------
// sc_mux_scan
//   Registered N-channel multiplexer with manual selection and an automatic
//   scan mode. In scan mode each channel stays on the output for
//   NUMBER_DWELL clock cycles, then the index moves to the next channel and
//   wraps around after the last one. A freeze input holds all state and the
//   output. newchan_Out pulses for one cycle whenever channel_Out changes.
//
//   Optional feature: define SC_MUXSCAN_SKIPMASK_EN to add
//   SC_MUXSCAN_mask_InBUS. Scan mode then visits only the channels whose
//   mask bit is 1. Manual mode always ignores the mask.
//
// Parameters
//   NUMBER_DATAWIDTH  width of one channel in bits
//   NUMBER_CHANNELS   number of channels (2..16)
//   NUMBER_DWELL      cycles spent on each channel in scan mode (1..255)
//
// Ports
//   SC_MUXSCAN_CLOCK_50     in   clock, rising edge
//   SC_MUXSCAN_RESET_InLow  in   asynchronous reset, active low
//   SC_MUXSCAN_data_InBUS   in   packed channels, channel k at [k*W +: W]
//   SC_MUXSCAN_select_InBUS in   manual channel index (clamped to N-1)
//   SC_MUXSCAN_mode_InLow   in   0 = scan, 1 = manual
//   SC_MUXSCAN_freeze_In    in   1 = hold everything
//   SC_MUXSCAN_mask_InBUS   in   channel enable mask (SC_MUXSCAN_SKIPMASK_EN only)
//   SC_MUXSCAN_z_Out        out  registered data of the selected channel
//   SC_MUXSCAN_channel_Out  out  index of the channel on z_Out
//   SC_MUXSCAN_newchan_Out  out  one-cycle pulse after channel_Out changes
// ---------------------------------------------------------------------------
module sc_mux_scan #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int NUMBER_CHANNELS  = 10,
  parameter int NUMBER_DWELL     = 4
) (
  input  logic                                        SC_MUXSCAN_CLOCK_50,
  input  logic                                        SC_MUXSCAN_RESET_InLow,
  input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] SC_MUXSCAN_data_InBUS,
  input  logic [3:0]                                  SC_MUXSCAN_select_InBUS,
  input  logic                                        SC_MUXSCAN_mode_InLow,
  input  logic                                        SC_MUXSCAN_freeze_In,
`ifdef SC_MUXSCAN_SKIPMASK_EN
  input  logic [NUMBER_CHANNELS-1:0]                  SC_MUXSCAN_mask_InBUS,
`endif
  output logic [NUMBER_DATAWIDTH-1:0]                 SC_MUXSCAN_z_Out,
  output logic [3:0]                                  SC_MUXSCAN_channel_Out,
  output logic                                        SC_MUXSCAN_newchan_Out
);

  localparam logic ST_MANUAL = 1'b0;
  localparam logic ST_SCAN   = 1'b1;

  localparam logic [3:0] LAST_IDX   = 4'(NUMBER_CHANNELS - 1);
  localparam logic [7:0] DWELL_LAST = 8'(NUMBER_DWELL - 1);

  logic       state;
  logic       state_next;
  logic [3:0] idx;
  logic [3:0] idx_next;
  logic [7:0] dcnt;
  logic [7:0] dcnt_next;
  logic [3:0] sel_clamped;
  logic [3:0] scan_next;

  // Channels unpacked into a full 16-entry table so that the 4-bit index
  // always addresses it exactly; unused entries read as zero.
  logic [NUMBER_DATAWIDTH-1:0] chan [16];

  for (genvar k = 0; k < 16; k++) begin : g_chan
    if (k < NUMBER_CHANNELS) begin : g_used
      assign chan[k] = SC_MUXSCAN_data_InBUS[k*NUMBER_DATAWIDTH +: NUMBER_DATAWIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  // Out-of-range manual selections stick to the last real channel.
  always_comb begin
    sel_clamped = SC_MUXSCAN_select_InBUS;
    if ({1'b0, SC_MUXSCAN_select_InBUS} >= 5'(NUMBER_CHANNELS)) begin
      sel_clamped = LAST_IDX;
    end
  end

`ifdef SC_MUXSCAN_SKIPMASK_EN
  logic [15:0] mask_ext;
  logic [4:0]  cand;
  logic        found;

  assign mask_ext = 16'(SC_MUXSCAN_mask_InBUS);

  // Search forward from idx+1 (wrapping) for the first enabled channel.
  // The last candidate is idx itself, so a mask with only the current
  // channel enabled keeps it; an all-zero mask finds nothing and holds idx.
  always_comb begin
    scan_next = idx;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUMBER_CHANNELS; k++) begin
      cand = {1'b0, idx} + 5'(k);
      if (cand >= 5'(NUMBER_CHANNELS)) begin
        cand = cand - 5'(NUMBER_CHANNELS);
      end
      if (!found && mask_ext[cand[3:0]]) begin
        scan_next = cand[3:0];
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    scan_next = idx + 4'd1;
    if (idx == LAST_IDX) begin
      scan_next = 4'd0;
    end
  end
`endif

  // Mode is sampled every edge: manual loads the clamped select, the first
  // scan edge keeps the current index and restarts the dwell, and later
  // scan edges advance once the dwell count reaches its last value.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    dcnt_next  = dcnt;
    if (SC_MUXSCAN_mode_InLow) begin
      state_next = ST_MANUAL;
      idx_next   = sel_clamped;
      dcnt_next  = 8'd0;
    end else if (state == ST_MANUAL) begin
      state_next = ST_SCAN;
      idx_next   = idx;
      dcnt_next  = 8'd0;
    end else if (dcnt == DWELL_LAST) begin
      idx_next   = scan_next;
      dcnt_next  = 8'd0;
    end else begin
      dcnt_next  = dcnt + 8'd1;
    end
  end

  // Freeze holds everything and suppresses the change pulse; any mode change
  // requested during freeze is simply evaluated on the first unfrozen edge.
  always_ff @(posedge SC_MUXSCAN_CLOCK_50 or negedge SC_MUXSCAN_RESET_InLow) begin
    if (!SC_MUXSCAN_RESET_InLow) begin
      state                  <= ST_MANUAL;
      idx                    <= 4'd0;
      dcnt                   <= 8'd0;
      SC_MUXSCAN_z_Out       <= '0;
      SC_MUXSCAN_channel_Out <= 4'd0;
      SC_MUXSCAN_newchan_Out <= 1'b0;
    end else if (SC_MUXSCAN_freeze_In) begin
      SC_MUXSCAN_newchan_Out <= 1'b0;
    end else begin
      state                  <= state_next;
      idx                    <= idx_next;
      dcnt                   <= dcnt_next;
      SC_MUXSCAN_z_Out       <= chan[idx_next];
      SC_MUXSCAN_channel_Out <= idx_next;
      SC_MUXSCAN_newchan_Out <= (idx_next != SC_MUXSCAN_channel_Out);
    end
  end

endmodule
